// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb path feeding the masked Keccak-f[1600] core.
package sha3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_PAD,
    ST_EXT,
    ST_GO,
    ST_WAIT
  } state_t;

  localparam int STATE_WORDS = 50;

  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;

  localparam int RATE_SHA3_224 = 36;
  localparam int RATE_SHA3_256 = 34;
  localparam int RATE_SHA3_384 = 26;
  localparam int RATE_SHA3_512 = 18;
  localparam int RATE_SHAKE128 = 42;
  localparam int RATE_SHAKE256 = 34;

  // Bytes are left-aligned: byte 0 sits at [31:24].
  function automatic logic [31:0] keep_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd0:    keep_mask = 32'h0000_0000;
      3'd1:    keep_mask = 32'hFF00_0000;
      3'd2:    keep_mask = 32'hFFFF_0000;
      3'd3:    keep_mask = 32'hFFFF_FF00;
      default: keep_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] byte_lane(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_lane = {b, 24'h0};
      2'd1:    byte_lane = {8'h0, b, 16'h0};
      2'd2:    byte_lane = {16'h0, b, 8'h0};
      default: byte_lane = {24'h0, b};
    endcase
  endfunction

endpackage

// File: rtl/sha3_absorb_ctrl_if.sv
// Two-share message word stream. A word transfers on a rising CLK edge where MSG_VALID and
// MSG_READY are both high; the source holds data/LAST/BYTES stable while VALID is high and not accepted.
interface sha3_absorb_ctrl_if;
  logic        MSG_VALID;
  logic        MSG_READY;
  logic [31:0] MSG_DATA_0;
  logic [31:0] MSG_DATA_1;
  logic        MSG_LAST;
  logic [2:0]  MSG_BYTES;

  modport master (
    output MSG_VALID, MSG_DATA_0, MSG_DATA_1, MSG_LAST, MSG_BYTES,
    input  MSG_READY
  );

  modport slave (
    input  MSG_VALID, MSG_DATA_0, MSG_DATA_1, MSG_LAST, MSG_BYTES,
    output MSG_READY
  );
endinterface

// File: rtl/sha3_pad_merge.sv
// Masks the tail of the last message word and merges pad10*1 plus the domain byte into share 0.
module sha3_pad_merge
  import sha3_pkg::*;
#(
  parameter int         RATE_WORDS = 34,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic [5:0]  wc,
  input  logic [2:0]  msg_bytes,
  input  logic        is_last,
  input  logic        is_pad,
  input  logic        dom_at0,
  input  logic [31:0] din_0,
  input  logic [31:0] din_1,
  output logic [31:0] dout_0,
  output logic [31:0] dout_1
);

  localparam logic [5:0] LAST_WC = 6'(RATE_WORDS - 1);

  logic [31:0] keep;
  logic [31:0] pad;
  logic        full_last;

  always_comb begin
    keep      = 32'hFFFF_FFFF;
    pad       = 32'h0;
    full_last = (msg_bytes >= 3'd4);
    if (is_pad)
      keep = 32'h0;
    else if (is_last)
      keep = keep_mask(msg_bytes);
    if (is_last && !full_last)
      pad = pad ^ byte_lane(DOMAIN, msg_bytes[1:0]);
    if (is_pad && dom_at0)
      pad = pad ^ byte_lane(DOMAIN, 2'd0);
    // A full last word at the block end owes its 0x80 to the following pad block instead.
    if ((wc == LAST_WC) && (is_pad || (is_last && !full_last)))
      pad = pad ^ 32'h0000_0080;
    // Shares stay separate: padding touches share 0 only.
    dout_0 = (din_0 & keep) ^ pad;
    dout_1 = din_1 & keep;
  end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Absorb sequencer: pads the two-share message stream and drives the Keccak core load/GO port block by block.
module sha3_absorb_ctrl #(
  parameter int         RATE_WORDS  = 34,
  parameter int         STATE_WORDS = 50,
  parameter logic [7:0] DOMAIN      = 8'h06
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  sha3_absorb_ctrl_if.slave   msg,
  output logic                K_INIT,
  output logic                K_GO,
  output logic                K_IN_READY,
  output logic                K_ABSORB,
  output logic                K_EXTEND,
  output logic [31:0]         K_DIN_0,
  output logic [31:0]         K_DIN_1,
  input  logic                K_DONE,
  output logic                BUSY,
  output logic                ABSORB_DONE,
  output sha3_pkg::state_t    STATE_DBG
);

  import sha3_pkg::*;

  localparam logic [5:0] RATE_W  = 6'(RATE_WORDS);
  localparam logic [5:0] EXT_LEN = 6'(STATE_WORDS - RATE_WORDS);

  state_t      state, state_nxt;
  logic [5:0]  wc, wc_nxt;
  logic [5:0]  ext_cnt, ext_cnt_nxt;
  logic        pad_pending, pad_pending_nxt;
  logic        dom_owed, dom_owed_nxt;
  logic        msg_done, msg_done_nxt;
  logic        init_nxt, go_nxt, in_ready_nxt, extend_nxt, absorb_done_nxt;
  logic [31:0] din_0_nxt, din_1_nxt;
  logic [31:0] mrg_0, mrg_1;
  logic        hs;
  logic        wc_full;

  assign msg.MSG_READY = (state == ST_LOAD);
  assign hs            = msg.MSG_VALID && (state == ST_LOAD);
  assign wc_full       = ((wc + 6'd1) == RATE_W);
  assign BUSY          = (state != ST_IDLE);
  assign STATE_DBG     = state;
  assign K_ABSORB      = K_IN_READY;

  sha3_pad_merge #(
    .RATE_WORDS (RATE_WORDS),
    .DOMAIN     (DOMAIN)
  ) u_pad_merge (
    .wc        (wc),
    .msg_bytes (msg.MSG_BYTES),
    .is_last   (hs && msg.MSG_LAST),
    .is_pad    (state == ST_PAD),
    .dom_at0   (dom_owed),
    .din_0     (msg.MSG_DATA_0),
    .din_1     (msg.MSG_DATA_1),
    .dout_0    (mrg_0),
    .dout_1    (mrg_1)
  );

  always_comb begin
    state_nxt       = state;
    wc_nxt          = wc;
    ext_cnt_nxt     = 6'd0;
    pad_pending_nxt = pad_pending;
    dom_owed_nxt    = dom_owed;
    msg_done_nxt    = msg_done;
    init_nxt        = 1'b0;
    go_nxt          = 1'b0;
    in_ready_nxt    = 1'b0;
    extend_nxt      = 1'b0;
    absorb_done_nxt = 1'b0;
    din_0_nxt       = 32'h0;
    din_1_nxt       = 32'h0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt       = ST_INIT;
          wc_nxt          = 6'd0;
          pad_pending_nxt = 1'b0;
          dom_owed_nxt    = 1'b0;
          msg_done_nxt    = 1'b0;
        end
      end
      ST_INIT: begin
        init_nxt  = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (hs) begin
          in_ready_nxt = 1'b1;
          din_0_nxt    = mrg_0;
          din_1_nxt    = mrg_1;
          wc_nxt       = wc + 6'd1;
          if (msg.MSG_LAST) begin
            msg_done_nxt = 1'b1;
            // A full final word pushes the domain byte into the next pad word (or next block).
            if (msg.MSG_BYTES >= 3'd4) begin
              dom_owed_nxt    = 1'b1;
              pad_pending_nxt = wc_full;
            end
            state_nxt = wc_full ? ST_EXT : ST_PAD;
          end else if (wc_full) begin
            state_nxt = ST_EXT;
          end
        end
      end
      ST_PAD: begin
        in_ready_nxt = 1'b1;
        din_0_nxt    = mrg_0;
        din_1_nxt    = mrg_1;
        dom_owed_nxt = 1'b0;
        wc_nxt       = wc + 6'd1;
        if (wc_full)
          state_nxt = ST_EXT;
      end
      ST_EXT: begin
        extend_nxt  = 1'b1;
        ext_cnt_nxt = ext_cnt + 6'd1;
        if ((ext_cnt + 6'd1) == EXT_LEN)
          state_nxt = ST_GO;
      end
      ST_GO: begin
        go_nxt    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (K_DONE) begin
          wc_nxt = 6'd0;
          if (pad_pending) begin
            pad_pending_nxt = 1'b0;
            state_nxt       = ST_PAD;
          end else if (msg_done) begin
            absorb_done_nxt = 1'b1;
            msg_done_nxt    = 1'b0;
            state_nxt       = ST_IDLE;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      wc          <= 6'd0;
      ext_cnt     <= 6'd0;
      pad_pending <= 1'b0;
      dom_owed    <= 1'b0;
      msg_done    <= 1'b0;
      K_INIT      <= 1'b0;
      K_GO        <= 1'b0;
      K_IN_READY  <= 1'b0;
      K_EXTEND    <= 1'b0;
      K_DIN_0     <= 32'h0;
      K_DIN_1     <= 32'h0;
      ABSORB_DONE <= 1'b0;
    end else begin
      state       <= state_nxt;
      wc          <= wc_nxt;
      ext_cnt     <= ext_cnt_nxt;
      pad_pending <= pad_pending_nxt;
      dom_owed    <= dom_owed_nxt;
      msg_done    <= msg_done_nxt;
      K_INIT      <= init_nxt;
      K_GO        <= go_nxt;
      K_IN_READY  <= in_ready_nxt;
      K_EXTEND    <= extend_nxt;
      K_DIN_0     <= din_0_nxt;
      K_DIN_1     <= din_1_nxt;
      ABSORB_DONE <= absorb_done_nxt;
    end
  end

endmodule
